// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin arbiter for the register-file write port, one registered writeback stage; define REG_WB_FWD_EN for the forwarding probe
module reg_wb_arbiter #(
  parameter int NREQ  = 3,
  parameter int CNT_W = 16
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iStall,
  input  logic [NREQ-1:0]     iReqValid,
  input  logic [5*NREQ-1:0]   iReqAddr,
  input  logic [32*NREQ-1:0]  iReqData,
  output logic [NREQ-1:0]     oReqReady,
  output logic                oWbEna,
  output logic [4:0]          oWbAddr,
  output logic [31:0]         oWbData,
  output logic [CNT_W-1:0]    oWbCount,
  input  logic [4:0]          iRdAddr,
  output logic                oFwdHit,
  output logic [31:0]         oFwdData
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr;
  logic [PW-1:0] nextPtr;
  logic [PW-1:0] idx;
  logic          grantAny;
  logic [4:0]    winAddr;
  logic [31:0]   winData;
  // pick the first valid requester scanning upward from the round-robin pointer
  always_comb begin
    oReqReady = '0;
    grantAny  = 1'b0;
    winAddr   = '0;
    winData   = '0;
    nextPtr   = ptr;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k >= NREQ) ? PW'(int'(ptr) + k - NREQ) : PW'(int'(ptr) + k);
      if (!grantAny && iReqValid[idx] && !iStall && iRst_n) begin
        grantAny       = 1'b1;
        oReqReady[idx] = 1'b1;
        winAddr        = iReqAddr[5*idx +: 5];
        winData        = iReqData[32*idx +: 32];
        nextPtr        = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
  // register the winner; writes to $zero complete but never raise the enable
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ptr      <= '0;
      oWbEna   <= 1'b0;
      oWbAddr  <= '0;
      oWbData  <= '0;
      oWbCount <= '0;
    end else begin
      oWbEna <= grantAny && (winAddr != 5'd0);
      if (grantAny) begin
        ptr     <= nextPtr;
        oWbAddr <= winAddr;
        oWbData <= winData;
      end
      if (oWbEna) oWbCount <= oWbCount + 1'b1;
    end
  end
`ifdef REG_WB_FWD_EN
  assign oFwdHit  = oWbEna && (oWbAddr == iRdAddr) && (iRdAddr != 5'd0);
  assign oFwdData = oFwdHit ? oWbData : 32'd0;
`else
  logic unusedRdAddr;
  assign unusedRdAddr = ^iRdAddr;
  assign oFwdHit      = 1'b0;
  assign oFwdData     = 32'd0;
`endif
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: randomized scoreboard bench for reg_wb_arbiter against a requester-level reference model
module tb_reg_wb_arbiter;
  localparam int NREQ  = 3;
  localparam int CNT_W = 4;
  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                stall = 1'b0;
  logic [NREQ-1:0]     vld = '0;
  logic [5*NREQ-1:0]   addrBus = '0;
  logic [32*NREQ-1:0]  dataBus = '0;
  logic [4:0]          rdAddr = '0;
  logic [NREQ-1:0]     ready;
  logic                wbEna;
  logic [4:0]          wbAddr;
  logic [31:0]         wbData;
  logic [CNT_W-1:0]    wbCount;
  logic                fwdHit;
  logic [31:0]         fwdData;
  int                  errors = 0;
  int                  checks = 0;
  int                  cyc = 0;
  int                  mPtr = 0;
  bit                  pend[NREQ];
  logic [4:0]          rAddr[NREQ];
  logic [31:0]         rData[NREQ];
  logic [4:0]          rdNext = '0;
  wr_t                 q[$];
  logic [4:0]          expAddr = '0;
  logic [31:0]         expData = '0;
  int                  expCnt = 0;

  reg_wb_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .iClk(clk), .iRst_n(rstn), .iStall(stall),
    .iReqValid(vld), .iReqAddr(addrBus), .iReqData(dataBus),
    .oReqReady(ready), .oWbEna(wbEna), .oWbAddr(wbAddr), .oWbData(wbData),
    .oWbCount(wbCount), .iRdAddr(rdAddr), .oFwdHit(fwdHit), .oFwdData(fwdData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic newReq(input int i, input logic [4:0] a, input logic [31:0] d);
    pend[i]  = 1'b1;
    rAddr[i] = a;
    rData[i] = d;
  endtask

  // one cycle: drive at posedge+1, predict and check grant before the next edge, return at posedge+1
  task automatic step(output int g);
    logic [NREQ-1:0] expReady;
    for (int i = 0; i < NREQ; i++) begin
      vld[i]              = pend[i];
      addrBus[5*i +: 5]   = rAddr[i];
      dataBus[32*i +: 32] = rData[i];
    end
    rdAddr = rdNext;
    #3;
    g = -1;
    if (rstn && !stall)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && pend[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    chk("ready", 64'(ready), 64'(expReady));
    if (g >= 0) begin
      q.push_back('{cyc + 1, rAddr[g], rData[g]});
      mPtr    = (g + 1) % NREQ;
      pend[g] = 1'b0;
    end
    rdNext = (g >= 0 && $urandom_range(0, 3) != 0) ? rAddr[g] : 5'($urandom_range(0, 31));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    int g;
    rstn = 1'b0;
    q.delete();
    mPtr    = 0;
    expAddr = '0;
    expData = '0;
    expCnt  = 0;
    step(g);
    rstn = 1'b1;
  endtask

  // scoreboard monitor: pops the write expected this cycle and checks the registered stage
  always @(negedge clk) begin
    logic        expEna;
    logic        eh;
    logic [31:0] ed;
    expEna = 1'b0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      wr_t it;
      it      = q.pop_front();
      expAddr = it.addr;
      expData = it.data;
      expEna  = (it.addr != 5'd0);
    end
    chk("wb_ena", 64'(wbEna), 64'(expEna));
    chk("wb_addr", 64'(wbAddr), 64'(expAddr));
    chk("wb_data", 64'(wbData), 64'(expData));
    chk("wb_count", 64'(wbCount), 64'(expCnt));
`ifdef REG_WB_FWD_EN
    eh = expEna && (expAddr == rdAddr) && (rdAddr != 5'd0);
    ed = eh ? expData : 32'd0;
`else
    eh = 1'b0;
    ed = 32'd0;
`endif
    chk("fwd_hit", 64'(fwdHit), 64'(eh));
    chk("fwd_data", 64'(fwdData), 64'(ed));
    if (expEna) expCnt = (expCnt + 1) % (1 << CNT_W);
  end

  initial begin
    int g;
    for (int i = 0; i < NREQ; i++) begin
      pend[i]  = 1'b0;
      rAddr[i] = '0;
      rData[i] = '0;
    end
    @(posedge clk);
    #1;
    doReset();
    step(g);
    // single requester, plain write
    newReq(1, 5'd5, 32'hDEADBEEF);
    step(g);
    chk("t1_grant", 64'(g), 64'(1));
    step(g);
    // all three valid after reset: strict rotation from requester 0
    doReset();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) newReq(i, 5'(i + 1), 32'h100 + 32'(n * NREQ + i));
      step(g);
      chk("t2_grant", 64'(g), 64'(n % NREQ));
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    step(g);
    // write to $zero is accepted but not enabled
    newReq(0, 5'd0, 32'h1234);
    step(g);
    chk("t3_grant", 64'(g), 64'(0));
    step(g);
    // stall holds off the grant, then stall right after a transfer
    stall = 1'b1;
    newReq(2, 5'd7, 32'hCAFE0007);
    for (int n = 0; n < 3; n++) step(g);
    stall = 1'b0;
    step(g);
    chk("t4_grant", 64'(g), 64'(2));
    stall = 1'b1;
    step(g);
    stall = 1'b0;
    // reset right after a transfer drops the pending write and the pointer
    newReq(1, 5'd11, 32'h0BAD0011);
    step(g);
    doReset();
    for (int i = 0; i < NREQ; i++) newReq(i, 5'(20 + i), 32'hF00 + 32'(i));
    step(g);
    chk("t5_grant", 64'(g), 64'(0));
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    step(g);
    // forwarding probe hit then miss
    newReq(0, 5'd9, 32'hA5A5A5A5);
    step(g);
    rdNext = 5'd9;
    step(g);
    newReq(0, 5'd9, 32'hA5A5A5A5);
    step(g);
    rdNext = 5'd8;
    step(g);
    // randomized traffic with occasional stalls and resets
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1)
          newReq(i, ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) doReset();
      else step(g);
    end
    stall = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    step(g);
    step(g);
    chk("drain", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
